norm_n: RTL and testbench
=========================

NORM_N -- requirements
Module: norm_n

Interface
REQ-001 Parameter WIDTH, default 32, operand width; legal values 16 and 32 (covers norm_s and norm_l).
REQ-002 Parameter STEP, default 1, bits examined per scan cycle; legal values 1, 2, 4, 8.
REQ-003 The block SHALL have the following ports, clock and reset first:
 clk  in  1  clock; all state updates on rising edge.
 reset  in  1  reset, synchronous, active-high.
 ready  in  1  start strobe; sampled only in IDLE.
 var_in  in  WIDTH  two's-complement operand.
 busy  out  1  high in SCAN and DONE.
 done  out  1  one-cycle result-valid pulse.
 norm  out  16  left-shift count; valid from done, held until next start.
 var_out  out  WIDTH  var_in << norm; present only per REQ-020.

Function
REQ-004 States: IDLE, SCAN, DONE.
REQ-005 IDLE with ready=0 SHALL hold all outputs.
REQ-006 IDLE with ready=1 at edge k and var_in==0: norm<=0, done<=1, -> DONE at edge k.
REQ-007 IDLE with ready=1 at edge k and var_in all ones: norm<=WIDTH-1, done<=1, -> DONE at edge k.
REQ-008 Otherwise at edge k: norm<=0; work register<=~var_in if var_in[WIDTH-1]=1, else var_in; -> SCAN.
REQ-009 SCAN, each edge: examine window bits [WIDTH-2 : WIDTH-1-STEP] of the work register, filling positions below bit 0 with zeros.
REQ-010 Window has a set bit: norm<=norm+(zeros above the highest set bit in the window); done<=1; -> DONE.
REQ-011 Window all zero: work register<<=STEP; norm<=norm+STEP; stay in SCAN.
REQ-012 Latency: for non-special operands, done SHALL rise at edge k+1+floor(norm/STEP); for special operands at edge k.
REQ-013 DONE, next edge: done<=0, work register<=0, -> IDLE; norm and var_out held.
REQ-014 ready outside IDLE SHALL be ignored; no queuing.
REQ-015 Result SHALL equal ITU norm_s/norm_l bit-exactly for every WIDTH-bit input; norm never exceeds WIDTH-1.
REQ-016 busy SHALL be combinational decode of state != IDLE.

Reset
REQ-017 reset=1 at an edge: state<=IDLE, norm<=0, done<=0, work register<=0, var_out<=0.
REQ-018 reset SHALL abort SCAN or DONE mid-operation with no done pulse; reset overrides a concurrent ready.

Configuration
REQ-019 Macro NORM_N_SHIFT_OUT_EN selects the shifted-value output.
REQ-020 NORM_N_SHIFT_OUT_EN defined: var_out registered, written with var_in<<norm on the edge done rises, held until next start. Undefined: var_out tied to 0 and the operand copy is not implemented.

Structure
REQ-021 Package norm_pkg SHALL hold the state enum, legal-parameter constants, and a width function for count fields.
REQ-022 Sub-module norm_lead_win SHALL be the STEP-bit combinational window leading-one encoder (found flag, zero count).
REQ-023 Parameter legality SHALL be checked at elaboration; illegal values cause a fatal error.

Verification
REQ-024 W=32,S=1, var_in=0x0000_4000 at edge k -> norm=16, done at edge k+17, var_out=0x4000_0000.
REQ-025 W=32, var_in=0xFFFF_FFFF -> norm=31 at edge k; var_in=0 -> norm=0 at edge k; var_in=0x8000_0000 -> norm=0.
REQ-026 W=16,S=1, var_in=0x0001 -> norm=14; var_in=0xFFFE -> norm=14; var_out=0x4000 and 0x8000 respectively.
REQ-027 W=32,S=4, var_in=0x0000_4000 -> norm=16, done at edge k+5; var_in=0x0000_0001 -> norm=30, done at edge k+8.
REQ-028 reset asserted 3 edges into SCAN -> no done, norm=0, IDLE; a following ready with var_in=0x0100_0000 -> norm=6.
REQ-029 ready held high through SCAN -> exactly one done pulse per accepted start; next start taken only from IDLE.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and helpers for the norm_n leading-sign normaliser.
package norm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } norm_state_e;

    localparam int LEGAL_WIDTH_S = 16;
    localparam int LEGAL_WIDTH_L = 32;
    localparam int NORM_OUT_W    = 16;

    function automatic bit legal_width(input int w);
        return (w == LEGAL_WIDTH_S) || (w == LEGAL_WIDTH_L);
    endfunction

    function automatic bit legal_step(input int s);
        return (s == 1) || (s == 2) || (s == 4) || (s == 8);
    endfunction

    // Bits needed to hold a count in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/norm_lead_win.sv
// Combinational leading-one encoder over a STEP-bit window: found flag and
// number of zeros above the highest set bit.
module norm_lead_win
    import norm_pkg::*;
#(
    parameter int STEP = 1,
    parameter int ZW   = cnt_width(STEP - 1)
) (
    input  logic [STEP-1:0] win,
    output logic            found,
    output logic [ZW-1:0]   zcnt
);

    // Scan LSB to MSB so the highest set bit writes last and wins.
    always_comb begin
        found = |win;
        zcnt  = {ZW{1'b0}};
        for (int i = 0; i < STEP; i++) begin
            zcnt = win[i] ? ZW'(STEP - 1 - i) : zcnt;
        end
    end

endmodule

// File: rtl/norm_n.sv
// Multi-cycle ITU norm_s/norm_l: counts left shifts needed to normalise a
// two's-complement operand. Define NORM_N_SHIFT_OUT_EN to add the shifted var_out.
module norm_n
    import norm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      var_in,
    output logic                  busy,
    output logic                  done,
    output logic [NORM_OUT_W-1:0] norm,
    output logic [WIDTH-1:0]      var_out
);

    localparam int NW = cnt_width(WIDTH - 1);
    localparam int ZW = cnt_width(STEP - 1);

    if (!legal_width(WIDTH)) begin : g_bad_width
        $fatal(1, "norm_n: WIDTH must be 16 or 32");
    end
    if (!legal_step(STEP)) begin : g_bad_step
        $fatal(1, "norm_n: STEP must be 1, 2, 4 or 8");
    end

    norm_state_e      state_q, state_d;
    logic [NW-1:0]    norm_q, norm_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [NW-1:0]    norm_sum_s;
    logic             win_found_s;
    logic [ZW-1:0]    win_zcnt_s;
`ifdef NORM_N_SHIFT_OUT_EN
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] var_out_q, var_out_d;
`endif

    // Window sits just below the sign position; for legal WIDTH/STEP it never
    // reaches below bit 0, so no zero fill is needed.
    norm_lead_win #(
        .STEP (STEP),
        .ZW   (ZW)
    ) u_win (
        .win   (work_q[WIDTH-2 -: STEP]),
        .found (win_found_s),
        .zcnt  (win_zcnt_s)
    );

    // Next-state and datapath decode for IDLE/SCAN/DONE.
    always_comb begin
        state_d    = state_q;
        norm_d     = norm_q;
        done_d     = 1'b0;
        work_d     = work_q;
        norm_sum_s = norm_q + NW'(win_zcnt_s);
`ifdef NORM_N_SHIFT_OUT_EN
        opnd_d     = opnd_q;
        var_out_d  = var_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    if (var_in == {WIDTH{1'b0}}) begin
                        norm_d  = {NW{1'b0}};
                        done_d  = 1'b1;
                        state_d = ST_DONE;
`ifdef NORM_N_SHIFT_OUT_EN
                        var_out_d = {WIDTH{1'b0}};
`endif
                    end else if (var_in == {WIDTH{1'b1}}) begin
                        norm_d  = NW'(WIDTH - 1);
                        done_d  = 1'b1;
                        state_d = ST_DONE;
`ifdef NORM_N_SHIFT_OUT_EN
                        var_out_d = {1'b1, {(WIDTH-1){1'b0}}};
`endif
                    end else begin
                        norm_d  = {NW{1'b0}};
                        work_d  = var_in[WIDTH-1] ? ~var_in : var_in;
                        state_d = ST_SCAN;
`ifdef NORM_N_SHIFT_OUT_EN
                        opnd_d  = var_in;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (win_found_s) begin
                    norm_d  = norm_sum_s;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
`ifdef NORM_N_SHIFT_OUT_EN
                    var_out_d = opnd_q << norm_sum_s;
`endif
                end else begin
                    work_d = work_q << STEP;
                    norm_d = norm_q + NW'(STEP);
                end
            end
            ST_DONE: begin
                work_d  = {WIDTH{1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                work_d  = {WIDTH{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            norm_q  <= {NW{1'b0}};
            done_q  <= 1'b0;
            work_q  <= {WIDTH{1'b0}};
`ifdef NORM_N_SHIFT_OUT_EN
            opnd_q    <= {WIDTH{1'b0}};
            var_out_q <= {WIDTH{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            norm_q  <= norm_d;
            done_q  <= done_d;
            work_q  <= work_d;
`ifdef NORM_N_SHIFT_OUT_EN
            opnd_q    <= opnd_d;
            var_out_q <= var_out_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign norm = NORM_OUT_W'(norm_q);
`ifdef NORM_N_SHIFT_OUT_EN
    assign var_out = var_out_q;
`else
    assign var_out = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_norm_n.sv
// Scoreboard bench for norm_n: three instances (W32/S1, W16/S1, W32/S4)
// checked against an independent ITU norm model.
module tb_norm_n;

    typedef struct {
        logic [15:0] norm;
        logic [31:0] vout;
        int          edge_n;
    } exp_t;

    exp_t sb [3][$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic        clk;
    logic        reset;
    logic [2:0]  ready;
    logic [31:0] vin [3];
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [15:0] norm_o [3];
    logic [31:0] vout [3];
    logic [15:0] vout1;

    assign vout[1] = {16'h0000, vout1};

    norm_n #(.WIDTH(32), .STEP(1)) u_d0 (
        .clk(clk), .reset(reset), .ready(ready[0]), .var_in(vin[0]),
        .busy(busy[0]), .done(done[0]), .norm(norm_o[0]), .var_out(vout[0]));
    norm_n #(.WIDTH(16), .STEP(1)) u_d1 (
        .clk(clk), .reset(reset), .ready(ready[1]), .var_in(vin[1][15:0]),
        .busy(busy[1]), .done(done[1]), .norm(norm_o[1]), .var_out(vout1));
    norm_n #(.WIDTH(32), .STEP(4)) u_d2 (
        .clk(clk), .reset(reset), .ready(ready[2]), .var_in(vin[2]),
        .busy(busy[2]), .done(done[2]), .norm(norm_o[2]), .var_out(vout[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int w_of(input int i);
        return (i == 1) ? 16 : 32;
    endfunction

    function automatic int s_of(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    // Reference: normalise by single-bit shifts, latency from the scan step.
    function automatic exp_t model(input int i, input logic [31:0] v, input int k);
        exp_t        e;
        int          w;
        int          n;
        int          lat;
        logic [31:0] mask;
        logic [31:0] x;
        logic [31:0] y;
        w    = w_of(i);
        mask = (w == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        x    = v & mask;
        n    = 0;
        lat  = 0;
        if (x == 32'd0) begin
            n = 0;
        end else if (x == mask) begin
            n = w - 1;
        end else begin
            y = x[w-1] ? (~x & mask) : x;
            while (!y[w-2] && n < w) begin
                y = y << 1;
                n++;
            end
            lat = 1 + n / s_of(i);
        end
        e.norm   = 16'(n);
`ifdef NORM_N_SHIFT_OUT_EN
        e.vout   = (x << n) & mask;
`else
        e.vout   = 32'd0;
`endif
        e.edge_n = k + lat;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                n_tests++;
                if (sb[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_done inst%0d: done=1 at edge %0d, required no pulse", i, cyc);
                end else begin
                    e = sb[i].pop_front();
                    if (norm_o[i] !== e.norm || vout[i] !== e.vout || cyc != e.edge_n) begin
                        n_fail++;
                        $display("FAIL result inst%0d: norm=%0d var_out=%h edge=%0d, required norm=%0d var_out=%h edge=%0d",
                                 i, norm_o[i], vout[i], cyc, e.norm, e.vout, e.edge_n);
                    end
                end
            end
        end
    end

    task automatic start(input int i, input logic [31:0] v);
        exp_t e;
        e = model(i, v, cyc + 1);
        vin[i]   = v;
        ready[i] = 1'b1;
        sb[i].push_back(e);
        @(negedge clk);
        ready[i] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d results pending, required 0", tag,
                     sb[0].size() + sb[1].size() + sb[2].size());
            for (int i = 0; i < 3; i++) sb[i].delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ready = 3'b000;
        for (int i = 0; i < 3; i++) vin[i] = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({busy[i], done[i], norm_o[i], vout[i]} !== 50'd0) begin
                n_fail++;
                $display("FAIL reset inst%0d: busy=%b done=%b norm=%0d var_out=%h, required all 0",
                         i, busy[i], done[i], norm_o[i], vout[i]);
            end
        end
    endtask

    task automatic test_special();
        start(0, 32'hFFFF_FFFF);
        n_tests++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_special: busy=%b, required 1", busy[0]);
        end
        wait_drain("special_ones");
        start(0, 32'h0000_0000);
        wait_drain("special_zero");
        start(0, 32'h8000_0000);
        wait_drain("special_min");
        start(1, 32'h0000_FFFF);
        wait_drain("special_ones16");
    endtask

    task automatic test_scan_s1();
        start(0, 32'h0000_4000);
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_scan: busy=%b done=%b, required busy=1 done=0", busy[0], done[0]);
        end
        wait_drain("s1_4000");
        start(1, 32'h0000_0001);
        wait_drain("s1_0001");
        start(1, 32'h0000_FFFE);
        wait_drain("s1_fffe");
    endtask

    task automatic test_step4();
        start(2, 32'h0000_4000);
        wait_drain("s4_4000");
        start(2, 32'h0000_0001);
        wait_drain("s4_0001");
        start(2, 32'hFFFF_FFFE);
        wait_drain("s4_fffffffe");
    endtask

    task automatic test_reset_abort();
        start(0, 32'h0000_4000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ready[0] = 1'b1;
        vin[0] = 32'h0000_0000;
        sb[0].delete();
        @(negedge clk);
        reset = 1'b0;
        ready[0] = 1'b0;
        n_tests++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || norm_o[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b done=%b norm=%0d, required 0 0 0",
                     busy[0], done[0], norm_o[0]);
        end
        repeat (20) @(negedge clk);
        start(0, 32'h0100_0000);
        wait_drain("after_abort");
    endtask

    task automatic test_ready_held();
        int pulses;
        pulses   = 0;
        vin[2]   = 32'h0000_4000;
        ready[2] = 1'b1;
        sb[2].push_back(model(2, 32'h0000_4000, cyc + 1));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done[2] === 1'b1) begin
                pulses++;
                ready[2] = 1'b0;
                break;
            end
        end
        ready[2] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done[2] === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || busy[2] !== 1'b0 || norm_o[2] !== 16'd16) begin
            n_fail++;
            $display("FAIL ready_held: pulses=%0d busy=%b norm=%0d, required 1 0 16",
                     pulses, busy[2], norm_o[2]);
        end
        wait_drain("ready_held");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 3; i++) begin
                v = $urandom() >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) v = ~v;
                if (r == 3) v = 32'd0;
                if (r == 7) v = 32'hFFFF_FFFF;
                start(i, v);
            end
            wait_drain("random");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ready = 3'b000;
        for (int i = 0; i < 3; i++) vin[i] = 32'd0;
        @(negedge clk);
        test_reset();
        test_special();
        test_scan_s1();
        test_step4();
        test_reset_abort();
        test_ready_held();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
